// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one single-port word memory between a fetch port and a load/store port.
// One access in flight: IDLE (grant) -> ACCESS (memory cycle) -> RESP (response pulse).
module mem_arbiter #(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 10,
    parameter bit RANGE_CHECK = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req,
    input  logic [31:0]       if_addr,
    output logic              if_ready,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_err,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [31:0]       d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ready,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_err,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_e;

    state_e              state_q, state_d;
    logic                last_d_q, last_d_d;   // 1: data port won the previous grant
    logic                port_d_q, port_d_d;   // 1: access in flight belongs to data port
    logic                we_q, we_d;
    logic                err_q, err_d;
    logic                mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
    logic                grant_d, grant_if;
    logic [31:0]         sel_addr;
    logic                sel_err;
    logic                resp, resp_data_ok;

    function automatic logic addr_err(input logic [31:0] a);
        logic e;
        e = |a[1:0];
        if (RANGE_CHECK) e = e | (|a[31:ADDR_W+2]);
        return e;
    endfunction

    // NOTE: every variable assigned in this block gets a default first so no latch is inferred.
    always_comb begin
        state_d     = state_q;
        last_d_d    = last_d_q;
        port_d_d    = port_d_q;
        we_d        = we_q;
        err_d       = err_q;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        grant_d     = 1'b0;
        grant_if    = 1'b0;
        sel_addr    = grant_d ? d_addr : if_addr;
        sel_err     = 1'b0;

        case (state_q)
            IDLE: begin
                grant_d  = d_req && (!if_req || !last_d_q);
                grant_if = if_req && !grant_d;
                sel_addr = grant_d ? d_addr : if_addr;
                sel_err  = addr_err(sel_addr);
                if (grant_d || grant_if) begin
                    state_d    = ACCESS;
                    last_d_d   = grant_d;
                    port_d_d   = grant_d;
                    we_d       = grant_d && d_we;
                    err_d      = sel_err;
                    mem_addr_d = sel_addr[ADDR_W+1:2];
                    mem_we_d   = grant_d && d_we && !sel_err;
                    if (grant_d) mem_wdata_d = d_wdata;
                end
            end
            ACCESS:  state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state and control registers use non-blocking assignments; the async reset also
    // kills mem_we at once so a store caught mid-ACCESS never reaches the memory.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            last_d_q    <= 1'b0;
            port_d_q    <= 1'b0;
            we_q        <= 1'b0;
            err_q       <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            last_d_q    <= last_d_d;
            port_d_q    <= port_d_d;
            we_q        <= we_d;
            err_q       <= err_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    // Ready is gated by rst_n so nothing appears accepted while reset is held.
    assign d_ready      = grant_d && rst_n;
    assign if_ready     = grant_if && rst_n;

    assign resp         = (state_q == RESP);
    assign resp_data_ok = resp && !we_q && !err_q;
    assign d_rvalid     = resp && port_d_q;
    assign if_rvalid    = resp && !port_d_q;
    assign d_err        = d_rvalid && err_q;
    assign if_err       = if_rvalid && err_q;
    assign d_rdata      = (resp_data_ok && port_d_q) ? mem_rdata : '0;
    assign if_rdata     = (resp_data_ok && !port_d_q) ? mem_rdata : '0;

    assign mem_we       = mem_we_q;
    assign mem_addr     = mem_addr_q;
    assign mem_wdata    = mem_wdata_q;

endmodule
